// File: rtl/paint_pkg.sv
// paint_pkg: shared types and constants for the paint input path
package paint_pkg;

    typedef enum logic [1:0] {KG_IDLE, KG_PRESS, KG_GAP} key_gen_state_t;

    localparam int KEY_GAP_MIN = 1;

endpackage

// File: rtl/key_req_fifo.sv
// key_req_fifo: small synchronous FIFO holding queued press-hold requests
module key_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("key_req_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_dout  = r_mem[r_rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/key_press_gen.sv
// key_press_gen: replays queued press requests as a clean keypress level with release gaps
module key_press_gen
    import paint_pkg::*;
#(
    parameter int HOLD_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [HOLD_W-1:0] i_req_hold,
    output logic              o_keypress,
    output logic              o_busy,
    output logic              o_done
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES < KEY_GAP_MIN) begin : g_gap_chk
        $error("key_press_gen: GAP_CYCLES must be at least 1");
    end

    key_gen_state_t    r_state;
    key_gen_state_t    w_next_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_next_hold;
    logic [GW-1:0]     r_gap_cnt;
    logic [GW-1:0]     w_next_gap;
    logic [HOLD_W-1:0] w_dout;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_busy_next;
    logic              r_keypress;
    logic              r_done;
    logic              r_busy;

    assign w_push      = i_req_valid && !w_full;
    assign o_req_ready = !w_full;
    assign o_keypress  = r_keypress;
    assign o_done      = r_done;
    assign o_busy      = r_busy;

    key_req_fifo #(
        .WIDTH (HOLD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_req_hold),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state logic: pop into PRESS, count down the hold, then count down the gap
    always_comb begin
        w_next_state = r_state;
        w_next_hold  = r_hold_cnt;
        w_next_gap   = r_gap_cnt;
        w_pop        = 1'b0;
        case (r_state)
            KG_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_hold  = (w_dout == '0) ? HOLD_W'(1) : w_dout;
                    w_next_state = KG_PRESS;
                end
            end
            KG_PRESS: begin
                w_next_hold = r_hold_cnt - 1'b1;
                if (r_hold_cnt == HOLD_W'(1)) begin
                    w_next_state = KG_GAP;
                    w_next_gap   = GW'(GAP_CYCLES);
                end
            end
            KG_GAP: begin
                w_next_gap = r_gap_cnt - 1'b1;
                if (r_gap_cnt == GW'(1)) w_next_state = KG_IDLE;
            end
            default: w_next_state = KG_IDLE;
        endcase
    end

    // Busy whenever work remains after this edge: a non-idle FSM, a queued entry or a new push
    assign w_busy_next = (w_next_state != KG_IDLE) || !w_empty || w_push;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= KG_IDLE;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_hold;
            r_gap_cnt  <= w_next_gap;
        end
    end

    // Registered outputs; keypress trails the PRESS state by one cycle so the key rises two edges after acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keypress <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_keypress <= r_state == KG_PRESS;
            r_done     <= (r_state == KG_GAP) && (r_gap_cnt == GW'(1));
            r_busy     <= w_busy_next;
        end
    end

endmodule

// File: tb/tb_key_press_gen.sv
// tb_key_press_gen: directed stimulus against a timeline model of press scheduling
module tb_key_press_gen;

    localparam int HOLD_W = 8;
    localparam int GAP    = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_req_valid = 1'b0;
    logic [HOLD_W-1:0] i_req_hold = '0;
    logic              o_req_ready;
    logic              o_keypress;
    logic              o_busy;
    logic              o_done;

    key_press_gen #(
        .HOLD_W     (HOLD_W),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_hold  (i_req_hold),
        .o_keypress  (o_keypress),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #50 clk = ~clk;

    // Downstream press detector: one pulse per rising keypress
    logic r_det_prev;
    logic w_det_pulse;
    always @(posedge clk) r_det_prev <= reset ? 1'b0 : o_keypress;
    assign w_det_pulse = o_keypress & ~r_det_prev;

    // Timeline model: per accepted request, acceptance edge, effective hold and first high edge
    int a_t [64];
    int h_v [64];
    int s_t [64];
    int n = 0;
    int cyc = 0;
    bit acc = 0;
    bit en = 0;
    bit rdy_prev = 0;
    int acc_cyc = 0;
    int checks = 0;
    int errors = 0;
    int runs [$];
    int lows [$];
    int kp_run = 0;
    int low_run = 0;
    bit had_press = 0;
    int pulses = 0;
    int dones = 0;
    int last_rise = 0;
    int ready_lows = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit exp_kp(int t);
        for (int i = 0; i < n; i++) if (t >= s_t[i] && t < s_t[i] + h_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_done(int t);
        for (int i = 0; i < n; i++) if (t == s_t[i] + h_v[i] + GAP - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy(int t);
        for (int i = 0; i < n; i++) if (t >= a_t[i] && t < s_t[i] + h_v[i] + GAP - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_cnt(int t);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            if (a_t[i] <= t) c++;
            if (s_t[i] - 1 <= t) c--;
        end
        return c;
    endfunction

    // Model update and per-cycle comparison; inputs change 1 time unit after this edge
    initial forever begin
        @(negedge clk);
        cyc++;
        acc = 1'b0;
        if (reset) begin
            n = 0;
            en = 1'b1;
            had_press = 1'b0;
            kp_run = 0;
            low_run = 0;
        end else if (i_req_valid && rdy_prev && n < 64) begin
            a_t[n] = cyc;
            h_v[n] = (i_req_hold == 0) ? 1 : int'(i_req_hold);
            s_t[n] = cyc + 2;
            if (n > 0 && s_t[n-1] + h_v[n-1] + GAP + 1 > s_t[n]) s_t[n] = s_t[n-1] + h_v[n-1] + GAP + 1;
            n++;
            acc = 1'b1;
        end
        if (en) begin
            chk("keypress", int'(o_keypress), int'(exp_kp(cyc)));
            chk("done", int'(o_done), int'(exp_done(cyc)));
            chk("busy", int'(o_busy), int'(exp_busy(cyc)));
            chk("req_ready", int'(o_req_ready), int'(exp_cnt(cyc) < DEPTH));
            if (w_det_pulse) pulses++;
            if (o_done) dones++;
            if (!o_req_ready) ready_lows++;
            if (!reset) begin
                if (o_keypress) begin
                    if (kp_run == 0) begin
                        last_rise = cyc;
                        if (had_press) lows.push_back(low_run);
                    end
                    kp_run++;
                end else begin
                    if (kp_run > 0) begin
                        runs.push_back(kp_run);
                        had_press = 1'b1;
                        low_run = 0;
                    end
                    kp_run = 0;
                    low_run++;
                end
            end
        end
        rdy_prev = exp_cnt(cyc) < DEPTH;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(int h);
        i_req_valid = 1'b1;
        i_req_hold = HOLD_W'(h);
        for (int k = 0; k < 64; k++) begin
            tick();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 0, 1);
        acc_cyc = cyc;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (!o_busy && !o_keypress) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        repeat (4) tick();
    endtask

    initial begin
        int p;
        int d;
        int r0;
        int a0;
        int sz;
        bit seen;
        int hs [5];
        repeat (3) tick();
        reset = 1'b0;
        tick();
        // single hold=3
        p = pulses; d = dones;
        send(3);
        wait_idle();
        chk("p1_run", runs[$], 3);
        chk("p1_latency", last_rise - acc_cyc, 2);
        chk("p1_done", dones - d, 1);
        chk("p1_pulse", pulses - p, 1);
        // hold=0 acts as 1
        p = pulses; d = dones;
        send(0);
        wait_idle();
        chk("p2_run", runs[$], 1);
        chk("p2_done", dones - d, 1);
        chk("p2_pulse", pulses - p, 1);
        // five back-to-back requests overflow the 4-deep queue
        p = pulses; d = dones; r0 = ready_lows;
        for (int i = 1; i <= 5; i++) send(i);
        wait_idle();
        sz = runs.size();
        for (int i = 0; i < 5; i++) chk("p3_run_order", runs[sz-5+i], i + 1);
        sz = lows.size();
        for (int i = 0; i < 4; i++) chk("p3_low_gap", lows[sz-4+i], GAP + 1);
        chk("p3_done", dones - d, 5);
        chk("p3_pulse", pulses - p, 5);
        chk("p3_ready_low_seen", int'(ready_lows > r0), 1);
        // push in the same edge as a pop with three entries queued
        r0 = ready_lows;
        send(6);
        a0 = acc_cyc;
        send(2); send(3); send(4);
        for (int k = 0; k < 64 && cyc < a0 + 9; k++) tick();
        send(5);
        chk("p4_accept_edge", acc_cyc, a0 + 10);
        wait_idle();
        chk("p4_ready_never_low", ready_lows - r0, 0);
        hs[0] = 6; hs[1] = 2; hs[2] = 3; hs[3] = 4; hs[4] = 5;
        sz = runs.size();
        for (int i = 0; i < 5; i++) chk("p4_run_order", runs[sz-5+i], hs[i]);
        // reset in the middle of a long press
        send(200);
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (o_keypress) begin
                seen = 1'b1;
                break;
            end
        end
        chk("p5_press_started", int'(seen), 1);
        repeat (50) tick();
        d = dones;
        reset = 1'b1;
        tick();
        chk("p5_kp_after_reset", int'(o_keypress), 0);
        chk("p5_busy_after_reset", int'(o_busy), 0);
        reset = 1'b0;
        repeat (20) tick();
        chk("p5_no_done", dones - d, 0);
        d = dones;
        send(2);
        wait_idle();
        chk("p5_run_after", runs[$], 2);
        chk("p5_done_after", dones - d, 1);
        // full-range hold
        d = dones;
        send(255);
        wait_idle();
        chk("p6_run", runs[$], 255);
        chk("p6_done", dones - d, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(100 * 20000);
        errors++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
